// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
//
// Bundles the handshake between the pipeline sequencing controller and the
// five-stage datapath.
//
//   slave  : the controller side (pipe_ctrl). It consumes the stage readiness
//            signals and produces the allowin/valid/accept/divide status.
//   master : the datapath side. It drives the readiness signals and consumes
//            the load enables and valid qualifiers.
//
// Signals
//   if_ready    fetch has an instruction available this cycle
//   id_ready    ID hazard check passed
//   exe_is_div  instruction in EXE is a divide (meaningful only while exe_valid)
//   mem_ready   data-memory response available for the MEM instruction
//   wb_flush    single-cycle exception/eret pulse from WB
//   *_allowin   stage may load its pipeline register this cycle
//   *_valid     stage holds a live instruction
//   if_accept   fetch instruction is consumed this cycle
//   div_busy    divide in progress in EXE, not yet done
//   div_cnt     cycles the current divide has spent in EXE
//
// DIV_LAT must match the DIV_LAT of the pipe_ctrl instance it connects to,
// because it sizes div_cnt.
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int DIV_LAT = 33
);
  localparam int CNT_W = $clog2(DIV_LAT);

  logic             if_ready;
  logic             id_ready;
  logic             exe_is_div;
  logic             mem_ready;
  logic             wb_flush;

  logic             id_allowin;
  logic             exe_allowin;
  logic             mem_allowin;
  logic             wb_allowin;

  logic             id_valid;
  logic             exe_valid;
  logic             mem_valid;
  logic             wb_valid;

  logic             if_accept;
  logic             div_busy;
  logic [CNT_W-1:0] div_cnt;

  modport slave (
    input  if_ready, id_ready, exe_is_div, mem_ready, wb_flush,
    output id_allowin, exe_allowin, mem_allowin, wb_allowin,
    output id_valid, exe_valid, mem_valid, wb_valid,
    output if_accept, div_busy, div_cnt
  );

  modport master (
    output if_ready, id_ready, exe_is_div, mem_ready, wb_flush,
    input  id_allowin, exe_allowin, mem_allowin, wb_allowin,
    input  id_valid, exe_valid, mem_valid, wb_valid,
    input  if_accept, div_busy, div_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//
// Sequencing controller for the five-stage MIPS core (IF/ID/EXE/MEM/WB).
// Owns the per-stage valid bits and the allowin/go handshake chain, runs the
// EXE divide occupancy counter, and clears the whole pipe on a WB flush.
//
// Ports
//   clk     core clock, all state on the rising edge
//   resetn  asynchronous active-low reset
//   bus     pipe_ctrl_if.slave (see pipe_ctrl_if for the signal list)
//
// Parameters
//   DIV_LAT number of cycles a divide occupies EXE; must be >= 2 so that the
//           counter has at least one "busy" cycle before it reports done.
//
// Valid bits and div_cnt are registers; allowin, if_accept and div_busy are
// combinational so a downstream stall reaches the front of the pipe in the
// same cycle it appears.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int DIV_LAT = 33
) (
  input  logic        clk,
  input  logic        resetn,
  pipe_ctrl_if.slave  bus
);

  localparam int               CNT_W    = $clog2(DIV_LAT);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_LAT - 1);

  // Stage state
  logic             id_valid_reg;
  logic             exe_valid_reg;
  logic             mem_valid_reg;
  logic             wb_valid_reg;
  logic [CNT_W-1:0] div_cnt_reg;

  // Go conditions: a stage's instruction has finished its work this cycle
  logic if_go;
  logic id_go;
  logic exe_go;
  logic mem_go;
  logic wb_go;
  logic div_done;

  // Allowin chain
  logic id_allowin;
  logic exe_allowin;
  logic mem_allowin;
  logic wb_allowin;

  // Divide sequencer controls
  logic exe_advance;
  logic div_step;

  // -------------------------------------------------------------------------
  // Go conditions
  // -------------------------------------------------------------------------
  assign div_done = (div_cnt_reg == DIV_LAST);

  assign if_go  = bus.if_ready;
  assign id_go  = bus.id_ready;
  // A non-divide finishes EXE in one cycle; a divide only once the counter
  // has reached its last cycle.
  assign exe_go = !bus.exe_is_div || div_done;
  assign mem_go = bus.mem_ready;
  assign wb_go  = 1'b1;

  // -------------------------------------------------------------------------
  // Allowin chain, evaluated back to front. An empty stage always accepts;
  // an occupied stage accepts only if its own instruction leaves this cycle.
  // -------------------------------------------------------------------------
  assign wb_allowin  = 1'b1;
  assign mem_allowin = !mem_valid_reg || (mem_go && wb_allowin);
  assign exe_allowin = !exe_valid_reg || (exe_go && mem_allowin);
  assign id_allowin  = !id_valid_reg  || (id_go  && exe_allowin);

  // -------------------------------------------------------------------------
  // Divide sequencer
  // -------------------------------------------------------------------------
  // The EXE instruction (divide or not) hands off to MEM at this edge.
  assign exe_advance = exe_valid_reg && exe_go && mem_allowin;
  // Counting stops at DIV_LAST, so a divide that is done but blocked by MEM
  // holds its count rather than wrapping.
  assign div_step    = exe_valid_reg && bus.exe_is_div && !div_done;

  // -------------------------------------------------------------------------
  // State update. Flush outranks every other event: whatever would have
  // advanced this edge (fetch accept, divide completion) is discarded.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_valid_reg  <= 1'b0;
      exe_valid_reg <= 1'b0;
      mem_valid_reg <= 1'b0;
      wb_valid_reg  <= 1'b0;
      div_cnt_reg   <= '0;
    end else if (bus.wb_flush) begin
      id_valid_reg  <= 1'b0;
      exe_valid_reg <= 1'b0;
      mem_valid_reg <= 1'b0;
      wb_valid_reg  <= 1'b0;
      div_cnt_reg   <= '0;
    end else begin
      // IF has no valid bit of its own; fetch presence is if_ready.
      if (id_allowin) begin
        id_valid_reg <= if_go;
      end
      // When ID is held by a hazard but EXE drains, this loads a bubble.
      if (exe_allowin) begin
        exe_valid_reg <= id_valid_reg && id_go;
      end
      if (mem_allowin) begin
        mem_valid_reg <= exe_valid_reg && exe_go;
      end
      if (wb_allowin) begin
        wb_valid_reg <= mem_valid_reg && mem_go;
      end

      if (exe_advance) begin
        div_cnt_reg <= '0;
      end else if (div_step) begin
        div_cnt_reg <= div_cnt_reg + CNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.id_allowin  = id_allowin;
  assign bus.exe_allowin = exe_allowin;
  assign bus.mem_allowin = mem_allowin;
  assign bus.wb_allowin  = wb_allowin;

  assign bus.id_valid    = id_valid_reg;
  assign bus.exe_valid   = exe_valid_reg;
  assign bus.mem_valid   = mem_valid_reg;
  assign bus.wb_valid    = wb_valid_reg;

  assign bus.if_accept   = bus.if_ready && id_allowin && !bus.wb_flush;
  assign bus.div_busy    = exe_valid_reg && bus.exe_is_div && !div_done;
  assign bus.div_cnt     = div_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
//
// Randomized bench for pipe_ctrl. The reference model tracks instructions as
// they flow through four occupancy slots (ID, EXE, MEM, WB), each carrying a
// divide flag, plus the age of the EXE occupant. Each cycle it works out
// which instructions leave their slot, derives the expected outputs from
// that, and then moves the instructions.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int DIV_LAT = 33;
  localparam int CNT_W   = $clog2(DIV_LAT);

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  pipe_ctrl_if #(.DIV_LAT(DIV_LAT)) bus ();

  pipe_ctrl #(.DIV_LAT(DIV_LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: slot 0=ID, 1=EXE, 2=MEM, 3=WB
  bit m_occ [4];
  bit m_div [4];
  int m_age;            // cycles the EXE occupant has spent in EXE

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_occ[s] = 1'b0;
      m_div[s] = 1'b0;
    end
    m_age = 0;
  endtask

  task automatic drive_idle();
    bus.if_ready   = 1'b0;
    bus.id_ready   = 1'b1;
    bus.exe_is_div = 1'b0;
    bus.mem_ready  = 1'b1;
    bus.wb_flush   = 1'b0;
  endtask

  // One clock cycle: drive random inputs (percent probabilities), compare
  // the DUT against the model, then advance the model to the next edge.
  task automatic do_cycle(input int p_if, input int p_id, input int p_mem,
                          input int p_div, input int p_flush);
    bit leave [4];
    bit room  [4];
    bit n_occ [4];
    bit n_div [4];
    int n_age;
    bit exe_done, take;
    int exp_cnt;

    @(negedge clk);
    cycle++;
    bus.if_ready   = ($urandom_range(99) < p_if);
    bus.id_ready   = ($urandom_range(99) < p_id);
    bus.mem_ready  = ($urandom_range(99) < p_mem);
    bus.wb_flush   = ($urandom_range(99) < p_flush);
    // The divide flag describes the EXE occupant; when EXE is empty it is
    // don't-care, so drive noise there.
    bus.exe_is_div = m_occ[1] ? m_div[1] : 1'($urandom_range(1));
    #1;

    // Which instructions would leave their slot this edge (ignoring flush)
    exe_done = !m_div[1] || (m_age >= DIV_LAT - 1);
    leave[3] = m_occ[3];
    room[3]  = 1'b1;
    leave[2] = m_occ[2] && bus.mem_ready;
    room[2]  = !m_occ[2] || leave[2];
    leave[1] = m_occ[1] && exe_done && room[2];
    room[1]  = !m_occ[1] || leave[1];
    leave[0] = m_occ[0] && bus.id_ready && room[1];
    room[0]  = !m_occ[0] || leave[0];
    take     = bus.if_ready && room[0] && !bus.wb_flush;

    if (m_occ[1] && m_div[1])
      exp_cnt = (m_age < DIV_LAT - 1) ? m_age : DIV_LAT - 1;
    else
      exp_cnt = 0;

    check("valid", {bus.wb_valid, bus.mem_valid, bus.exe_valid, bus.id_valid},
          {m_occ[3], m_occ[2], m_occ[1], m_occ[0]});
    check("allowin", {bus.wb_allowin, bus.mem_allowin, bus.exe_allowin, bus.id_allowin},
          {1'b1, room[2], room[1], room[0]});
    check("if_accept", bus.if_accept, take);
    check("div_cnt", bus.div_cnt, exp_cnt);
    check("div_busy", bus.div_busy, m_occ[1] && m_div[1] && (m_age < DIV_LAT - 1));

    if (bus.wb_flush) begin
      model_reset();
    end else begin
      n_occ[3] = leave[2];
      n_div[3] = leave[2] && m_div[2];
      n_occ[2] = leave[1] || (m_occ[2] && !leave[2]);
      n_div[2] = leave[1] ? m_div[1] : (n_occ[2] && m_div[2]);
      n_occ[1] = leave[0] || (m_occ[1] && !leave[1]);
      n_div[1] = leave[0] ? m_div[0] : (n_occ[1] && m_div[1]);
      n_occ[0] = take || (m_occ[0] && !leave[0]);
      n_div[0] = take ? ($urandom_range(99) < p_div) : (n_occ[0] && m_div[0]);
      if (leave[0])
        n_age = 0;
      else if (m_occ[1] && !leave[1])
        n_age = m_age + 1;
      else
        n_age = 0;
      for (int s = 0; s < 4; s++) begin
        m_occ[s] = n_occ[s];
        m_div[s] = n_div[s];
      end
      m_age = n_age;
    end
  endtask

  task automatic run_segment(input int n, input int p_if, input int p_id,
                             input int p_mem, input int p_div, input int p_flush);
    for (int i = 0; i < n; i++)
      do_cycle(p_if, p_id, p_mem, p_div, p_flush);
  endtask

  initial begin
    model_reset();
    drive_idle();
    resetn = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state, with fetch offering an instruction
    bus.if_ready = 1'b1;
    #1;
    check("rst_valid", {bus.wb_valid, bus.mem_valid, bus.exe_valid, bus.id_valid}, 0);
    check("rst_allowin", {bus.wb_allowin, bus.mem_allowin, bus.exe_allowin, bus.id_allowin}, 4'hf);
    check("rst_accept", bus.if_accept, 1);
    check("rst_div_cnt", bus.div_cnt, 0);
    check("rst_div_busy", bus.div_busy, 0);

    // Release with fetch idle so the first edge after release changes nothing
    @(negedge clk);
    drive_idle();
    resetn = 1'b1;

    run_segment(200, 100, 100, 100, 0, 0);   // free-flowing, one retire per cycle
    run_segment(300, 80, 60, 70, 0, 0);      // hazards and memory misses
    run_segment(600, 90, 80, 60, 30, 0);     // divides, some blocked by MEM
    run_segment(400, 90, 80, 80, 20, 3);     // flushes hitting live divides

    // Asynchronous reset in the middle of a memory stall
    run_segment(150, 100, 90, 10, 30, 0);
    @(negedge clk);
    bus.if_ready  = 1'b1;
    bus.mem_ready = 1'b0;
    bus.wb_flush  = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("async_valid", {bus.wb_valid, bus.mem_valid, bus.exe_valid, bus.id_valid}, 0);
    check("async_allowin", {bus.wb_allowin, bus.mem_allowin, bus.exe_allowin, bus.id_allowin}, 4'hf);
    check("async_div_cnt", bus.div_cnt, 0);
    check("async_accept", bus.if_accept, 1);
    model_reset();
    repeat (2) @(negedge clk);
    drive_idle();
    resetn = 1'b1;

    run_segment(600, 70, 70, 50, 25, 2);     // mixed traffic after reset

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
